// File: rtl/store_buffer.sv
// Posted-store buffer in front of the data memory: FIFO of pending stores drained when loads leave the port idle.
// Optional STORE_BUF_FWD_EN: forward the youngest matching pending store to loads instead of stalling them.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              ld_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_drain;
  logic [DEPTH-1:0]  w_valid;
  logic [DEPTH-1:0]  w_hit_vec;
  logic              w_hit;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign st_ready = !w_full;
  assign empty    = w_empty;
  assign w_push   = st_valid && st_ready;

  // An entry is live when its distance from head is below the occupancy.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ent
      logic [PTR_W-1:0] w_age;
      assign w_age         = PTR_W'(gi) - r_head;
      assign w_valid[gi]   = ({1'b0, w_age} < r_count);
      assign w_hit_vec[gi] = w_valid[gi] && (r_addr[gi] == ld_addr);
    end
  endgenerate

  assign w_hit = |w_hit_vec;

`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] w_fwd_data;
  logic [PTR_W-1:0]  w_scan_idx;

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    w_fwd_data = '0;
    w_scan_idx = r_head;
    for (int k = 0; k < DEPTH; k++) begin
      w_scan_idx = r_head + PTR_W'(k);
      if (w_hit_vec[w_scan_idx]) w_fwd_data = r_data[w_scan_idx];
    end
  end
`endif

  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    ld_data        = '0;
    ld_stall       = 1'b0;
    w_drain        = 1'b0;
    if (w_full) begin
      ld_stall = ld_req;
      w_drain  = 1'b1;
    end else if (ld_req) begin
      if (w_hit) begin
`ifdef STORE_BUF_FWD_EN
        ld_data = w_fwd_data;
`else
        ld_stall = 1'b1;
`endif
        w_drain = 1'b1;
      end else begin
        mem_read    = 1'b1;
        mem_address = ld_addr;
        ld_data     = mem_read_data;
      end
    end else if (!w_empty) begin
      w_drain = 1'b1;
    end
    if (w_drain) begin
      mem_write      = 1'b1;
      mem_address    = r_addr[r_head];
      mem_write_data = r_data[r_head];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)  r_tail <= r_tail + PTR_W'(1);
      if (w_drain) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_drain);
    end
  end

  // Payload storage needs no reset; liveness comes from the pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr;
      r_data[r_tail] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes and load results are queued at issue
// time and checked by a monitor on the falling edge; a small data-memory model sits on the mem port.
module tb_store_buffer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       st_valid;
  logic       st_ready;
  logic [7:0] st_addr;
  logic [7:0] st_data;
  logic       ld_req;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       ld_stall;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_write_data;
  logic [7:0] mem_read_data;
  logic       empty;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .empty(empty)
  );

`ifdef STORE_BUF_FWD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  logic [7:0] mem [256];
  assign mem_read_data = mem[mem_address];
  always @(posedge clk) if (mem_write) mem[mem_address] <= mem_write_data;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    mem[8'h80] <= 8'h5C;
    mem[8'h20] <= 8'h99;
    mem[8'h50] <= 8'h3C;
  end

  typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_wr [$];
  logic [7:0] exp_ld [$];
  wr_t        mon_w;
  logic [7:0] mon_l;
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_write) begin
      if (exp_wr.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got addr=%02h data=%02h want none", mem_address, mem_write_data);
      end else begin
        mon_w = exp_wr.pop_front();
        $display("wr   addr=%02h data=%02h", mem_address, mem_write_data);
        chk("wr_addr", int'(mem_address), int'(mon_w.a));
        chk("wr_data", int'(mem_write_data), int'(mon_w.d));
      end
    end
    if (ld_req && !ld_stall) begin
      if (exp_ld.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_load: got addr=%02h data=%02h want none", ld_addr, ld_data);
      end else begin
        mon_l = exp_ld.pop_front();
        $display("ld   addr=%02h data=%02h", ld_addr, ld_data);
        chk("ld_data", int'(ld_data), int'(mon_l));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (!empty && n < 20) begin step(); n++; end
    chk(nm, int'(empty), 1);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    exp_wr.push_back({a, d});
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    ld_req = 1'b1; ld_addr = a;
    exp_ld.push_back(d);
  endtask

  // Holds a load until it stops stalling; returns the number of stalled cycles.
  task automatic hold_load(input logic [7:0] a, output int stalls);
    int n = 0;
    ld_req = 1'b1; ld_addr = a; stalls = 0;
    #1;
    while (ld_stall && n < 10) begin stalls++; n++; step(); end
    chk("hold_load_timeout", int'(ld_stall), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    reset_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_req = 1'b0; ld_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st_ready", int'(st_ready), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_mem_write", int'(mem_write), 0);
    chk("rst_mem_read", int'(mem_read), 0);
    chk("rst_ld_stall", int'(ld_stall), 0);
    chk("rst_ld_data", int'(ld_data), 0);
    chk("rst_mem_address", int'(mem_address), 0);
    chk("rst_mem_wdata", int'(mem_write_data), 0);
    reset_n = 1'b1;
    step();

    // single store, drained the next cycle
    store(8'h10, 8'hA5);
    #1 chk("store_cycle_no_write", int'(mem_write), 0);
    step();
    st_valid = 1'b0;
    #1 chk("drain_mem_write", int'(mem_write), 1);
    chk("drain_mem_address", int'(mem_address), 8'h10);
    step();
    #1 chk("empty_after_drain", int'(empty), 1);
    load(8'h10, 8'hA5);
    step();
    ld_req = 1'b0;

    // fill under continuous missing loads
    for (int i = 0; i < 4; i++) begin
      store(8'(i + 1), 8'(8'h41 + i));
      load(8'h80, 8'h5C);
      #1 chk("fill_st_ready", int'(st_ready), 1);
      step();
    end
    st_valid = 1'b0;
    ld_req = 1'b1; ld_addr = 8'h80;
    #1 chk("full_st_ready", int'(st_ready), 0);
    chk("full_ld_stall", int'(ld_stall), 1);
    chk("full_drain_addr", int'(mem_address), 8'h01);
    step();
    load(8'h80, 8'h5C);
    #1 chk("post_full_stall", int'(ld_stall), 0);
    chk("post_full_mem_read", int'(mem_read), 1);
    chk("post_full_no_write", int'(mem_write), 0);
    step();
    ld_req = 1'b0;
    wait_empty("fill_drain_timeout");

    // two stores to one address, then a load of it
    store(8'h20, 8'h11); load(8'h80, 8'h5C); step();
    store(8'h20, 8'h22); load(8'h80, 8'h5C); step();
    st_valid = 1'b0;
    hold_load(8'h20, stalls);
    exp_ld.push_back(8'h22);
    chk("fwd_stall_cycles", stalls, (FWD != 0) ? 0 : 2);
    chk("fwd_mem_read", int'(mem_read), (FWD != 0) ? 0 : 1);
    chk("fwd_ld_data", int'(ld_data), 8'h22);
    step();
    ld_req = 1'b0;
    wait_empty("fwd_drain_timeout");

    // store and load to the same address in one cycle: load is older
    store(8'h30, 8'h77); load(8'h30, 8'h00);
    #1 chk("same_cycle_ld_data", int'(ld_data), 8'h00);
    step();
    st_valid = 1'b0;
    hold_load(8'h30, stalls);
    exp_ld.push_back(8'h77);
    chk("next_cycle_ld_data", int'(ld_data), 8'h77);
    step();
    ld_req = 1'b0;
    wait_empty("same_drain_timeout");

    // reset with three pending stores discards them
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 8'(8'h50 + i); st_data = 8'(8'hE0 + i);
      load(8'h80, 8'h5C);
      step();
    end
    st_valid = 1'b0; ld_req = 1'b0; reset_n = 1'b0;
    #1 chk("midrst_no_write", int'(mem_write), 0);
    chk("midrst_empty", int'(empty), 1);
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("post_rst_no_write", int'(mem_write), 0);
      step();
    end
    chk("post_rst_empty", int'(empty), 1);
    chk("post_rst_mem50", int'(mem[8'h50]), 8'h3C);
    chk("wr_queue_left", exp_wr.size(), 0);
    chk("ld_queue_left", exp_ld.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
